// File: rtl/grf_pkg.sv
// Shared types and sizing for the GRF write-port controller.
// Holds the controller state encoding and the requester identifiers.
package grf_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } grf_state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with combinational grants.
// The pointer names who wins a tie and always moves to the loser after a grant.
module rr_arb2
  import grf_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  req_id_e rr_q;
  req_id_e rr_d;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (req_i == 2'b11) begin
        gnt_o = (rr_q == REQ_A) ? 2'b01 : 2'b10;
      end else begin
        gnt_o = req_i;
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (gnt_o[0]) begin
      rr_d = REQ_B;
    end else if (gnt_o[1]) begin
      rr_d = REQ_A;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q <= REQ_A;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: rtl/grf_ctrl.sv
// GRF write-port controller: zeroes registers 1..NREG-1 after reset or on
// request, then arbitrates the single registered write port between A and B.
module grf_ctrl #(
  parameter int DATA_W = grf_pkg::DATA_W,
  parameter int ADDR_W = grf_pkg::ADDR_W,
  parameter int NREG   = grf_pkg::NREG
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_start,
  output logic              busy,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_gnt,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_gnt,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata
);

  import grf_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREG - 1);

  grf_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              arb_en;
  logic [1:0]        gnt;

  // A clear request pre-empts any grant in the cycle it is seen.
  assign arb_en = (state_q == RUN) && !clr_start;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en_i  (arb_en),
    .req_i ({b_req, a_req}),
    .gnt_o (gnt)
  );

  assign a_gnt = gnt[0];
  assign b_gnt = gnt[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      CLEAR: begin
        we_d    = 1'b1;
        waddr_d = cnt_q;
        wdata_d = '0;
        cnt_d   = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_ADDR) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // Entering a clear issues the write to register 1 on the same edge.
        if (clr_start) begin
          state_d = CLEAR;
          we_d    = 1'b1;
          waddr_d = ADDR_W'(1);
          wdata_d = '0;
          cnt_d   = ADDR_W'(2);
        end else if (gnt[0]) begin
          we_d    = (a_addr != '0);
          waddr_d = a_addr;
          wdata_d = a_data;
        end else if (gnt[1]) begin
          we_d    = (b_addr != '0);
          waddr_d = b_addr;
          wdata_d = b_data;
        end
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
    busy_d = (state_d == CLEAR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q   <= ADDR_W'(1);
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign busy  = busy_q;

endmodule
